// File: rtl/ulpi_pkg.sv
// Shared types and TX CMD encodings for the ULPI register-access link controller.
package ulpi_pkg;

  typedef enum logic [3:0] {
    StReset,
    StWait,
    StIdle,
    StCmd,
    StWdata,
    StStp,
    StRdTa,
    StRdData,
    StRdEnd
  } ulpi_state_e;

  localparam logic [1:0] TXCMD_REGWR = 2'b10;
  localparam logic [1:0] TXCMD_REGRD = 2'b11;
  localparam logic [7:0] TXCMD_NOOP  = 8'h00;

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side controller: PHY reset sequencing, immediate register read/write with
// abort/retry, RX CMD capture and a free-running heartbeat.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 64,
  parameter int unsigned WAIT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned HB_WIDTH    = 27
) (
  input  logic       ulpi_clk,
  input  logic       resetn,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  output logic       ulpi_phy_resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd,
  output logic       link_ready,
  output logic       heartbeat
);

  localparam int unsigned CntMax = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  ulpi_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              abort_q, abort_d;
  logic              write_q, write_d;
  logic [5:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rxcmd_valid_q, rxcmd_valid_d;
  logic [7:0]        rxcmd_q, rxcmd_d;
  logic              dir_q, dir_d;
  logic [HB_WIDTH-1:0] hb_q, hb_d;

  assign link_ready      = (state_q == StIdle) && !ulpi_dir;
  assign req_ready       = link_ready && !rsp_valid_q;
  assign ulpi_phy_resetn = (state_q != StReset);
  assign ulpi_stp        = (state_q == StReset) || (state_q == StWait) || (state_q == StStp);
  assign ulpi_data_oe    = ((state_q == StCmd) || (state_q == StWdata) || (state_q == StStp)) &&
                           !ulpi_dir;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign rxcmd_valid     = rxcmd_valid_q;
  assign rxcmd           = rxcmd_q;
  assign heartbeat       = hb_q[HB_WIDTH-1];

  always_comb begin
    ulpi_data_o = TXCMD_NOOP;
    case (state_q)
      StCmd:   ulpi_data_o = {(write_q ? TXCMD_REGWR : TXCMD_REGRD), addr_q};
      StWdata: ulpi_data_o = wdata_q;
      default: ulpi_data_o = TXCMD_NOOP;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    abort_d       = abort_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = 8'h00;
    rsp_err_d     = 1'b0;
    rxcmd_valid_d = 1'b0;
    rxcmd_d       = rxcmd_q;
    dir_d         = ulpi_dir;
    hb_d          = hb_q + HB_WIDTH'(1);

    case (state_q)
      StReset: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        if (cnt_q == CntW'(WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        if (req_valid && req_ready) begin
          state_d = StCmd;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          retry_d = '0;
          abort_d = 1'b0;
        end
      end
      StCmd, StWdata: begin
        if (ulpi_dir) begin
          // abort_q marks an abort already counted; keep waiting for the PHY to release the bus
          if (!(state_q == StCmd && abort_q)) begin
            if (retry_q == RetryW'(MAX_RETRY)) begin
              state_d     = StIdle;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else begin
              retry_d = retry_q + RetryW'(1);
              abort_d = 1'b1;
              state_d = StCmd;
            end
          end
        end else begin
          abort_d = 1'b0;
          if (ulpi_nxt) begin
            if (state_q == StWdata) begin
              state_d = StStp;
            end else begin
              state_d = write_q ? StWdata : StRdTa;
            end
          end
        end
      end
      StStp: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
      end
      StRdTa: begin
        if (ulpi_dir) state_d = StRdData;
      end
      StRdData: begin
        state_d     = StRdEnd;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ulpi_data_i;
      end
      StRdEnd: begin
        if (!ulpi_dir) state_d = StIdle;
      end
      default: state_d = StReset;
    endcase

    // dir_q low means this is the turnaround cycle, which carries no valid data
    if ((state_q == StIdle || state_q == StRdEnd) && ulpi_dir && dir_q && !ulpi_nxt) begin
      rxcmd_valid_d = 1'b1;
      rxcmd_d       = ulpi_data_i;
    end
  end

  always_ff @(posedge ulpi_clk) begin
    if (!resetn) begin
      state_q       <= StReset;
      cnt_q         <= '0;
      retry_q       <= '0;
      abort_q       <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rxcmd_valid_q <= 1'b0;
      rxcmd_q       <= '0;
      dir_q         <= 1'b0;
      hb_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      abort_q       <= abort_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rxcmd_valid_q <= rxcmd_valid_d;
      rxcmd_q       <= rxcmd_d;
      dir_q         <= dir_d;
      hb_q          <= hb_d;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Bench for ulpi_reg_ctrl: PHY model driven from tables and hand sequences, responses
// checked through an expected-response queue.
module tb_ulpi_reg_ctrl;

  localparam int unsigned RstCycles  = 64;
  localparam int unsigned WaitCycles = 1024;
  localparam int unsigned MaxRetry   = 3;
  localparam int unsigned HbWidth    = 11;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         nxt_dly;
    logic [7:0] rdata;
    logic [7:0] exp_cmd;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic       ulpi_phy_resetn;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rxcmd_valid;
  logic [7:0] rxcmd;
  logic       link_ready;
  logic       heartbeat;

  int   n_vec = 0;
  int   n_miss = 0;
  int   rsp_count = 0;
  rsp_t sb[$];
  rsp_t mon_exp;
  vec_t vecs[6];
  logic [HbWidth-1:0] hb_ref;

  always #8 clk = ~clk;

  ulpi_reg_ctrl #(
    .RST_CYCLES (RstCycles),
    .WAIT_CYCLES(WaitCycles),
    .MAX_RETRY  (MaxRetry),
    .HB_WIDTH   (HbWidth)
  ) u_dut (
    .ulpi_clk       (clk),
    .resetn         (resetn),
    .ulpi_data_i    (ulpi_data_i),
    .ulpi_data_o    (ulpi_data_o),
    .ulpi_data_oe   (ulpi_data_oe),
    .ulpi_dir       (ulpi_dir),
    .ulpi_nxt       (ulpi_nxt),
    .ulpi_stp       (ulpi_stp),
    .ulpi_phy_resetn(ulpi_phy_resetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rxcmd_valid    (rxcmd_valid),
    .rxcmd          (rxcmd),
    .link_ready     (link_ready),
    .heartbeat      (heartbeat)
  );

  always @(posedge clk) begin
    if (!resetn) hb_ref <= '0;
    else hb_ref <= hb_ref + 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 err=%0b rdata=%02h, expected none",
                 rsp_err, rsp_rdata);
      end else begin
        mon_exp = sb.pop_front();
        chk("rsp_err", rsp_err, mon_exp.err);
        chk("rsp_rdata", rsp_rdata, mon_exp.rdata);
      end
    end
  end

  task automatic reset_seq(input int cycles);
    int lo = 0;
    int wt = 0;
    int stp_bad = 0;
    resetn = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      #1;
      chk("rst_phy_resetn", ulpi_phy_resetn, 0);
      chk("rst_stp", ulpi_stp, 1);
      chk("rst_oe", ulpi_data_oe, 0);
      chk("rst_data_o", ulpi_data_o, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rxcmd_valid", rxcmd_valid, 0);
      chk("rst_link_ready", link_ready, 0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (link_ready) break;
      if (!ulpi_phy_resetn) lo++;
      else wt++;
      if (!ulpi_stp) stp_bad++;
      tick();
    end
    chk("phy_reset_cycles", lo, RstCycles);
    chk("wait_cycles", wt, WaitCycles);
    chk("stp_before_ready", stp_bad, 0);
    chk("link_ready_up", link_ready, 1);
    chk("stp_idle", ulpi_stp, 0);
    chk("heartbeat", heartbeat, hb_ref[HbWidth-1]);
  endtask

  task automatic do_txn(input vec_t v);
    rsp_t e;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    #1 chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    e.err   = 1'b0;
    e.rdata = v.wr ? 8'h00 : v.rdata;
    sb.push_back(e);
    for (int k = 0; k <= v.nxt_dly; k++) begin
      ulpi_nxt = (k == v.nxt_dly);
      #1;
      chk("txcmd", ulpi_data_o, v.exp_cmd);
      chk("txcmd_oe", ulpi_data_oe, 1);
      if (k == 0) chk("req_ready_busy", req_ready, 0);
      tick();
    end
    if (v.wr) begin
      ulpi_nxt = 1'b1;
      #1 chk("wdata", ulpi_data_o, v.wdata);
      tick();
      ulpi_nxt = 1'b0;
      #1 chk("stp_pulse", ulpi_stp, 1);
      chk("stp_data", ulpi_data_o, 0);
      tick();
      #1 chk("stp_release", ulpi_stp, 0);
      chk("req_ready_rsp", req_ready, 0);
      tick();
    end else begin
      ulpi_nxt = 1'b0;
      ulpi_dir = 1'b1;
      #1 chk("rd_ta_oe", ulpi_data_oe, 0);
      tick();
      ulpi_data_i = v.rdata;
      #1 chk("rd_data_oe", ulpi_data_oe, 0);
      tick();
      ulpi_dir    = 1'b0;
      ulpi_data_i = 8'h00;
      #1 chk("req_ready_rsp", req_ready, 0);
      tick();
    end
    #1 chk("req_ready_after", req_ready, 1);
  endtask

  initial begin
    int saved;
    rsp_t e;
    logic exp_pulse;
    resetn      = 1'b0;
    ulpi_data_i = 8'h00;
    ulpi_dir    = 1'b0;
    ulpi_nxt    = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 6'h00;
    req_wdata   = 8'h00;

    vecs[0] = '{1'b1, 6'h0A, 8'h45, 2, 8'h00, 8'h8A};
    vecs[1] = '{1'b0, 6'h16, 8'h00, 0, 8'hA5, 8'hD6};
    vecs[2] = '{1'b1, 6'h3F, 8'hFF, 0, 8'h00, 8'hBF};
    vecs[3] = '{1'b0, 6'h00, 8'h00, 1, 8'h3C, 8'hC0};
    vecs[4] = '{1'b1, 6'h01, 8'h00, 3, 8'h00, 8'h81};
    vecs[5] = '{1'b0, 6'h2A, 8'h00, 0, 8'h5A, 8'hEA};

    reset_seq(5);
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Abort in WDATA, single retry, then normal completion
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h12; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    e.err = 1'b0; e.rdata = 8'h00; sb.push_back(e);
    ulpi_nxt = 1'b1;
    #1 chk("wab_cmd", ulpi_data_o, 8'h92);
    tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
    #1 chk("wab_oe_dir", ulpi_data_oe, 0);
    tick();
    #1 chk("wab_cmd_hold", ulpi_data_o, 8'h92);
    chk("wab_oe_hold", ulpi_data_oe, 0);
    tick();
    ulpi_dir = 1'b0;
    #1 chk("wab_retry_cmd", ulpi_data_o, 8'h92);
    chk("wab_retry_oe", ulpi_data_oe, 1);
    tick();
    ulpi_nxt = 1'b1;
    tick();
    #1 chk("wab_wdata", ulpi_data_o, 8'h77);
    tick();
    ulpi_nxt = 1'b0;
    #1 chk("wab_stp", ulpi_stp, 1);
    tick();
    tick();

    // Four aborts in CMD: three retries, then an error response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h05;
    tick();
    req_valid = 1'b0;
    e.err = 1'b1; e.rdata = 8'h00; sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
      #1 chk("abort_cmd", ulpi_data_o, 8'hC5);
      chk("abort_cmd_oe", ulpi_data_oe, 1);
      tick();
      ulpi_dir = 1'b1;
      #1 chk("abort_oe", ulpi_data_oe, 0);
      tick();
      if (i < 3) begin
        #1 chk("abort_no_rsp", rsp_valid, 0);
        tick();
      end
    end
    ulpi_dir = 1'b0;
    #1 chk("abort_err_pulse", rsp_valid, 1);
    tick();
    #1 chk("abort_ready_after", req_ready, 1);

    // RX CMD: three dir-high cycles, turnaround cycle not captured
    for (int i = 0; i < 6; i++) begin
      ulpi_dir    = (i < 3);
      ulpi_data_i = (i < 3) ? 8'h4C : 8'h00;
      exp_pulse   = (i == 2) || (i == 3);
      #1 chk("rxcmd_valid", rxcmd_valid, exp_pulse);
      if (i < 3) chk("link_ready_dir", link_ready, 0);
      tick();
    end
    #1 chk("rxcmd_value", rxcmd, 8'h4C);
    chk("link_ready_back", link_ready, 1);

    // Reset during WDATA: transaction dropped, full PHY reset sequence
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h0A; req_wdata = 8'h45;
    tick();
    req_valid = 1'b0;
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    #1 chk("mid_wdata", ulpi_data_o, 8'h45);
    saved = rsp_count;
    reset_seq(2);
    chk("mid_no_rsp", rsp_count, saved);

    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ulpi_reg_ctrl.md
ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 64: ulpi_clk cycles ulpi_phy_resetn is held low after reset.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1024: cycles after PHY reset release before link_ready.
REQ-003 SHALL have parameter MAX_RETRY, default 3: aborted-transfer retries before an error response.
REQ-004 SHALL have parameter HB_WIDTH, default 27: heartbeat counter width.
REQ-005 ulpi_clk  in  1  sole clock, PHY-sourced 60 MHz.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 ulpi_data_i  in  8  ULPI data from pad.
REQ-008 ulpi_data_o  out  8  ULPI data to pad.
REQ-009 ulpi_data_oe  out  1  pad output enable.
REQ-010 ulpi_dir / ulpi_nxt  in  1 each  PHY bus direction / throttle.
REQ-011 ulpi_stp  out  1  link stop.
REQ-012 ulpi_phy_resetn  out  1  PHY reset, active-low.
REQ-013 req_valid, req_ready (out), req_write, req_addr[5:0], req_wdata[7:0]  register request, valid/ready.
REQ-014 rsp_valid, rsp_rdata[7:0], rsp_err  out  one-cycle response pulse.
REQ-015 rxcmd_valid  out  1, rxcmd  out  8  RX CMD capture.
REQ-016 link_ready  out  1; heartbeat  out  1 = heartbeat counter MSB.

Function
REQ-017 FSM states SHALL be RESET, WAIT, IDLE, CMD, WDATA, STP, RD_TA, RD_DATA, RD_END.
REQ-018 RESET: ulpi_phy_resetn=0 for RST_CYCLES cycles, then WAIT; WAIT: phy_resetn=1 for WAIT_CYCLES, then IDLE.
REQ-019 ulpi_stp SHALL be 1 in RESET and WAIT, 0 in IDLE.
REQ-020 link_ready and req_ready SHALL be 1 only in IDLE with ulpi_dir=0.
REQ-021 Accepted request SHALL drive TX CMD next cycle: {2'b10,addr} for write, {2'b11,addr} for read; held until ulpi_nxt sampled 1.
REQ-022 Write: after CMD accepted, WDATA drives req_wdata until nxt=1; then STP one cycle with stp=1, data_o=8'h00; then rsp_valid=1, rsp_err=0, IDLE.
REQ-023 Read: after CMD accepted, RD_TA waits for dir=1 (turnaround cycle, not sampled); RD_DATA captures ulpi_data_i next cycle; rsp_valid=1 with rsp_rdata one cycle later; RD_END waits dir=0, then IDLE.
REQ-024 ulpi_data_oe SHALL equal (state in CMD/WDATA/STP) AND NOT ulpi_dir, combinationally; data_o=8'h00 elsewhere.
REQ-025 dir=1 during CMD or WDATA before nxt acceptance SHALL abort: wait for dir=0, retry from CMD, increment retry count.
REQ-026 Abort with retry count = MAX_RETRY SHALL return rsp_valid=1, rsp_err=1, rsp_rdata=0, IDLE.
REQ-027 In IDLE/RD_END, dir=1 on this and previous cycle with nxt=0 SHALL pulse rxcmd_valid one cycle later, rxcmd=ulpi_data_i; rxcmd holds until next capture.
REQ-028 First dir=1 cycle after dir=0 (turnaround) SHALL never be captured.
REQ-029 Heartbeat counter SHALL free-run from reset, wrapping at 2^HB_WIDTH.
REQ-030 Only one request in flight; req_ready=0 from acceptance to the rsp_valid cycle inclusive.

Reset
REQ-031 resetn=0 sampled on ulpi_clk SHALL force RESET, counters 0, ulpi_phy_resetn=0, stp=1, all other outputs 0.
REQ-032 Reset mid-transaction SHALL abandon it without rsp_valid and restart the full PHY reset sequence.

Structure
REQ-033 Package ulpi_pkg SHALL hold the state enum, TXCMD_REGWR=2'b10, TXCMD_REGRD=2'b11, TXCMD_NOOP=8'h00.
REQ-034 Single FSM module; no sub-module; pad tristate stays outside in top.

Verification
REQ-035 resetn low 5 cycles -> phy_resetn low 64 cycles, link_ready high after 1024 more; stp=1 until then.
REQ-036 Write addr 0x0A data 0x45, PHY nxt 2 cycles after CMD -> data_o 0x8A, then 0x45, stp one cycle, rsp_err=0.
REQ-037 Read addr 0x16, PHY turns around, returns 0xA5 -> data_o 0xD6, rsp_rdata=0xA5, oe low while dir=1.
REQ-038 PHY asserts dir during CMD 4 times -> 3 retries, then rsp_err=1.
REQ-039 Idle, PHY dir high 3 cycles, nxt=0, data 0x4C -> rxcmd_valid pulses twice, none on turnaround cycle.
REQ-040 resetn low during WDATA -> no rsp_valid, phy_resetn low 64 cycles.
